// File: rtl/ternary_mac_array.sv
// Ternary-weight MAC array: NUM_CH channels share one data vector and each accumulates
// NUM_CYC beats of a {-1,0,+1}-weighted dot product through a three-stage pipeline.
module ternary_mac_array #(
    parameter int LOG2_NO_VECS = 2,
    parameter int IN_BW        = 4,
    parameter int IN_SIGNED    = 1,
    parameter int NUM_CH       = 2,
    parameter int NUM_CYC      = 32,
    parameter int OUT_BW       = IN_BW + 1 + LOG2_NO_VECS + $clog2(NUM_CYC)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clear,
    input  logic                                   in_vld,
    input  logic [(IN_BW << LOG2_NO_VECS)-1:0]     data_in,
    input  logic [(NUM_CH << (LOG2_NO_VECS+1))-1:0] w_vec,
    output logic                                   out_vld,
    output logic [NUM_CH*OUT_BW-1:0]               data_out,
    output logic [NUM_CH-1:0]                      sat
);

    localparam int NO_VECS = 1 << LOG2_NO_VECS;
    localparam int P_BW    = IN_BW + 1;
    localparam int S_BW    = P_BW + LOG2_NO_VECS;
    localparam int CNT_BW  = $clog2(NUM_CYC);
    localparam int FULL_BW = S_BW + CNT_BW;

    // 2'b10 is reserved and decodes to zero, never to -2.
    function automatic logic signed [P_BW-1:0] tern_mul(input logic [IN_BW-1:0] d,
                                                        input logic [1:0]       w);
        logic signed [P_BW-1:0] x;
        x = (IN_SIGNED != 0) ? {d[IN_BW-1], d} : {1'b0, d};
        case (w)
            2'b01:   return x;
            2'b11:   return -x;
            2'b00:   return '0;
            2'b10:   return '0;
            default: return '0;
        endcase
    endfunction

    logic [CNT_BW-1:0]      cnt_r;
    logic                   accept_s;
    logic                   first_s;
    logic                   last_s;

    logic signed [P_BW-1:0] prod_s     [NUM_CH][NO_VECS];
    logic signed [P_BW-1:0] s1_prod_r  [NUM_CH][NO_VECS];
    logic                   s1_vld_r;
    logic                   s1_first_r;
    logic                   s1_last_r;

    logic signed [S_BW-1:0] sum_s      [NUM_CH];
    logic signed [S_BW-1:0] s2_sum_r   [NUM_CH];
    logic                   s2_vld_r;
    logic                   s2_first_r;
    logic                   s2_last_r;

    logic signed [FULL_BW-1:0] acc_next_s [NUM_CH];
    logic signed [FULL_BW-1:0] acc_r      [NUM_CH];

    logic [NUM_CH*OUT_BW-1:0] res_s;
    logic [NUM_CH-1:0]        sat_s;
    logic                     out_vld_r;
    logic [NUM_CH*OUT_BW-1:0] data_out_r;
    logic [NUM_CH-1:0]        sat_r;

    assign accept_s = in_vld & ~clear;
    assign first_s  = (cnt_r == '0);
    assign last_s   = (cnt_r == CNT_BW'(NUM_CYC - 1));

    // Beat counter: moves only on accepted beats, wraps after the last beat of a group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (in_vld) begin
            if (last_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_BW'(1);
            end
        end
    end

    // Per-element ternary products for every channel.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            for (int j = 0; j < NO_VECS; j++) begin
                prod_s[c][j] = tern_mul(data_in[j*IN_BW +: IN_BW], w_vec[(c*NO_VECS+j)*2 +: 2]);
            end
        end
    end

    // Stage S1: products plus the valid/first/last tags of the beat that produced them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_r   <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int j = 0; j < NO_VECS; j++) begin
                    s1_prod_r[c][j] <= '0;
                end
            end
        end else begin
            s1_vld_r   <= accept_s;
            s1_first_r <= accept_s & first_s;
            s1_last_r  <= accept_s & last_s;
            if (accept_s) begin
                s1_prod_r <= prod_s;
            end
        end
    end

    // Adder tree: sign-extend each product to the tree width before summing.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            sum_s[c] = '0;
            for (int j = 0; j < NO_VECS; j++) begin
                sum_s[c] = sum_s[c] + S_BW'(s1_prod_r[c][j]);
            end
        end
    end

    // Stage S2: per-channel beat sums; clear kills anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_r   <= 1'b0;
            s2_first_r <= 1'b0;
            s2_last_r  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                s2_sum_r[c] <= '0;
            end
        end else begin
            s2_vld_r   <= s1_vld_r & ~clear;
            s2_first_r <= s1_first_r & ~clear;
            s2_last_r  <= s1_last_r & ~clear;
            if (s1_vld_r && !clear) begin
                s2_sum_r <= sum_s;
            end
        end
    end

    // First beat of a group loads, later beats add; the load makes back-to-back groups free.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (s2_first_r) begin
                acc_next_s[c] = FULL_BW'(s2_sum_r[c]);
            end else begin
                acc_next_s[c] = acc_r[c] + FULL_BW'(s2_sum_r[c]);
            end
        end
    end

    generate
        if (OUT_BW < FULL_BW) begin : g_clamp
            localparam logic signed [FULL_BW-1:0] MAX_V =
                {{(FULL_BW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
            localparam logic signed [FULL_BW-1:0] MIN_V =
                {{(FULL_BW-OUT_BW+1){1'b1}}, {(OUT_BW-1){1'b0}}};

            // Saturate each channel into the narrower output range.
            always_comb begin
                res_s = '0;
                sat_s = '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (acc_next_s[c] > MAX_V) begin
                        res_s[c*OUT_BW +: OUT_BW] = MAX_V[OUT_BW-1:0];
                        sat_s[c]                  = 1'b1;
                    end else if (acc_next_s[c] < MIN_V) begin
                        res_s[c*OUT_BW +: OUT_BW] = MIN_V[OUT_BW-1:0];
                        sat_s[c]                  = 1'b1;
                    end else begin
                        res_s[c*OUT_BW +: OUT_BW] = acc_next_s[c][OUT_BW-1:0];
                        sat_s[c]                  = 1'b0;
                    end
                end
            end
        end else begin : g_extend
            // Output is wide enough: sign-extend, never saturate.
            always_comb begin
                res_s = '0;
                sat_s = '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    res_s[c*OUT_BW +: OUT_BW] = OUT_BW'(acc_next_s[c]);
                    sat_s[c]                  = 1'b0;
                end
            end
        end
    endgenerate

    // Stage S3: accumulators advance only on valid, un-cleared beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_r[c] <= '0;
            end
        end else if (s2_vld_r && !clear) begin
            acc_r <= acc_next_s;
        end
    end

    // Result registers: strobe for one cycle on a group's last beat, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_r  <= 1'b0;
            data_out_r <= '0;
            sat_r      <= '0;
        end else begin
            out_vld_r <= s2_vld_r & s2_last_r & ~clear;
            if (s2_vld_r && s2_last_r && !clear) begin
                data_out_r <= res_s;
                sat_r      <= sat_s;
            end
        end
    end

    assign out_vld  = out_vld_r;
    assign data_out = data_out_r;
    assign sat      = sat_r;

endmodule

// File: tb/tb_ternary_mac_array.sv
// Self-checking bench for ternary_mac_array: a group-level arithmetic model predicts every
// strobe, and two instances (full width and 6-bit saturating) share the same stimulus.
module tb_ternary_mac_array;

    localparam int NCYC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_vld;
    logic [15:0] data_in;
    logic [15:0] w_vec;
    logic        out_vld9;
    logic        out_vld6;
    logic [17:0] dout9;
    logic [11:0] dout6;
    logic [1:0]  sat9;
    logic [1:0]  sat6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ternary_mac_array #(.LOG2_NO_VECS(2), .IN_BW(4), .IN_SIGNED(1), .NUM_CH(2),
                        .NUM_CYC(NCYC)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_vld(in_vld), .data_in(data_in),
        .w_vec(w_vec), .out_vld(out_vld9), .data_out(dout9), .sat(sat9));

    ternary_mac_array #(.LOG2_NO_VECS(2), .IN_BW(4), .IN_SIGNED(1), .NUM_CH(2),
                        .NUM_CYC(NCYC), .OUT_BW(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_vld(in_vld), .data_in(data_in),
        .w_vec(w_vec), .out_vld(out_vld6), .data_out(dout6), .sat(sat6));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int s9(input int c);
        logic signed [8:0] v;
        v = dout9[c*9 +: 9];
        return int'(v);
    endfunction

    function automatic int s6(input int c);
        logic signed [5:0] v;
        v = dout6[c*6 +: 6];
        return int'(v);
    endfunction

    function automatic int wt(input logic [1:0] w);
        case (w)
            2'b01:   return 1;
            2'b11:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int dot(input int c);
        int s;
        logic signed [3:0] d;
        s = 0;
        for (int j = 0; j < 4; j++) begin
            d = data_in[j*4 +: 4];
            s += int'(d) * wt(w_vec[(c*4+j)*2 +: 2]);
        end
        return s;
    endfunction

    function automatic int clampv(input int v, input int bw);
        int hi;
        int lo;
        hi = (1 << (bw-1)) - 1;
        lo = -(1 << (bw-1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // ---- behavioural model: groups of NCYC accepted beats, result two edges after the last
    typedef struct {
        int due;
        int v0;
        int v1;
    } strobe_t;

    strobe_t pend[$];
    int      edge_no = 0;
    int      beat_cnt = 0;
    int      gacc[2];
    int      ev_vld = 0;
    int      e9[2];
    int      e6[2];
    int      es9 = 0;
    int      es6 = 0;
    int      last_beat_edge = 0;
    int      strobes = 0;
    int      strobe_edge = 0;
    int      prev_strobe_edge = 0;

    initial begin
        e9 = '{0, 0};
        e6 = '{0, 0};
        gacc = '{0, 0};
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            ev_vld = 0;
            if (!rst_n) begin
                pend.delete();
                beat_cnt = 0;
                e9 = '{0, 0};
                e6 = '{0, 0};
                es9 = 0;
                es6 = 0;
            end else if (clear) begin
                pend.delete();
                beat_cnt = 0;
            end else begin
                if (pend.size() > 0 && pend[0].due == edge_no) begin
                    strobe_t s;
                    s = pend.pop_front();
                    ev_vld = 1;
                    e9[0] = clampv(s.v0, 9);
                    e9[1] = clampv(s.v1, 9);
                    e6[0] = clampv(s.v0, 6);
                    e6[1] = clampv(s.v1, 6);
                    es9 = ((e9[0] != s.v0) ? 1 : 0) + ((e9[1] != s.v1) ? 2 : 0);
                    es6 = ((e6[0] != s.v0) ? 1 : 0) + ((e6[1] != s.v1) ? 2 : 0);
                end
                if (in_vld) begin
                    if (beat_cnt == 0) gacc = '{0, 0};
                    gacc[0] += dot(0);
                    gacc[1] += dot(1);
                    beat_cnt++;
                    if (beat_cnt == NCYC) begin
                        pend.push_back('{edge_no + 2, gacc[0], gacc[1]});
                        beat_cnt = 0;
                        last_beat_edge = edge_no;
                    end
                end
            end
            if (out_vld9) begin
                strobes++;
                prev_strobe_edge = strobe_edge;
                strobe_edge = edge_no;
            end
            chk("out_vld9", int'(out_vld9), ev_vld);
            chk("out_vld6", int'(out_vld6), ev_vld);
            for (int c = 0; c < 2; c++) begin
                chk("dout9", s9(c), e9[c]);
                chk("dout6", s6(c), e6[c]);
            end
            chk("sat9", int'(sat9), es9);
            chk("sat6", int'(sat6), es6);
        end
    end

    // ---- stimulus: inputs change on the falling edge
    task automatic beat(input logic [3:0] d, input logic [1:0] w0, input logic [1:0] w1,
                        input logic v);
        @(negedge clk);
        data_in = {4{d}};
        w_vec   = {{4{w1}}, {4{w0}}};
        in_vld  = v;
        clear   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_vld = 1'b0;
            clear  = 1'b0;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        clear   = 1'b0;
        in_vld  = 1'b0;
        data_in = '0;
        w_vec   = '0;
        repeat (2) @(negedge clk);
        chk("reset_vld", int'(out_vld9), 0);
        chk("reset_dout", int'(dout9), 0);
        rst_n = 1'b1;

        // data 3, ch0 +1, ch1 -1
        strobes = 0;
        repeat (4) beat(4'd3, 2'b01, 2'b11, 1'b1);
        idle(6);
        chk("s1_strobes", strobes, 1);
        chk("s1_latency", strobe_edge - last_beat_edge, 2);
        chk("s1_ch0", s9(0), 48);
        chk("s1_ch1", s9(1), -48);
        chk("s1_sat", int'(sat9), 0);

        // reserved weight decodes to zero; back-to-back groups
        strobes = 0;
        repeat (8) beat(4'd7, 2'b10, 2'b10, 1'b1);
        idle(6);
        chk("s3_strobes", strobes, 2);
        chk("s3_gap", strobe_edge - prev_strobe_edge, 4);
        chk("s3_ch0", s9(0), 0);
        chk("s3_ch1", s9(1), 0);

        // bubbles between beats
        strobes = 0;
        repeat (4) begin
            beat(4'd3, 2'b01, 2'b11, 1'b1);
            beat(4'd3, 2'b01, 2'b11, 1'b0);
        end
        idle(6);
        chk("s2_strobes", strobes, 1);
        chk("s2_latency", strobe_edge - last_beat_edge, 2);
        chk("s2_ch0", s9(0), 48);
        chk("s2_ch1", s9(1), -48);

        // data -8: saturation on the 6-bit instance
        repeat (4) beat(4'd8, 2'b01, 2'b11, 1'b1);
        idle(6);
        chk("s4_ch0_6", s6(0), -32);
        chk("s4_ch1_6", s6(1), 31);
        chk("s4_sat6", int'(sat6), 3);
        chk("s4_ch0_9", s9(0), -128);
        chk("s4_ch1_9", s9(1), 128);
        chk("s4_sat9", int'(sat9), 0);

        // clear aborts a partial group, even with in_vld high on the clear edge
        strobes = 0;
        repeat (2) beat(4'd5, 2'b01, 2'b01, 1'b1);
        @(negedge clk);
        clear  = 1'b1;
        in_vld = 1'b1;
        repeat (4) beat(4'd1, 2'b01, 2'b01, 1'b1);
        idle(6);
        chk("s5_strobes", strobes, 1);
        chk("s5_ch0", s9(0), 16);
        chk("s5_ch1", s9(1), 16);

        // asynchronous reset mid-group
        repeat (3) beat(4'd2, 2'b01, 2'b00, 1'b1);
        @(negedge clk);
        rst_n  = 1'b0;
        in_vld = 1'b0;
        #1;
        chk("s6_rst_vld", int'(out_vld9), 0);
        chk("s6_rst_ch0", s9(0), 0);
        chk("s6_rst_sat6", int'(sat6), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        strobes = 0;
        repeat (4) beat(4'd2, 2'b01, 2'b00, 1'b1);
        idle(6);
        chk("s6_strobes", strobes, 1);
        chk("s6_ch0", s9(0), 32);
        chk("s6_ch1", s9(1), 0);

        // randomized traffic with bubbles and occasional clear
        repeat (1500) begin
            @(negedge clk);
            data_in = 16'($urandom);
            w_vec   = 16'($urandom);
            in_vld  = ($urandom_range(0, 3) != 0);
            clear   = ($urandom_range(0, 31) == 0);
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
